// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: pipeline-register/memory status in, stage enables,
// flushes and status out. CNT_W must match the controller's CNT_W.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             ID_EX_memread;
  logic [4:0]       ID_EX_rd;
  logic [4:0]       IF_ID_rs1;
  logic [4:0]       IF_ID_rs2;
  logic             IF_ID_use_rs2;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ID_EX_memread, ID_EX_rd, IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs2,
           branch_taken, mem_req, mem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_timeout, stall_cnt
  );

  modport slave (
    input  ID_EX_memread, ID_EX_rd, IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs2,
           branch_taken, mem_req, mem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, branch flushes and
// data-memory wait handling with a timeout watchdog and a stall counter.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input logic                  clk,
  input logic                  Rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e            state_r, state_next_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_next_s;
  logic              pend_flush_r, pend_flush_next_s;
  logic              mem_timeout_r, mem_timeout_next_s;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              lu_s, mh_s;
  logic              pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s;
  logic              if_id_flush_s, id_ex_flush_s;

  // Hazard detection from the current ID/EX and memory-port inputs.
  always_comb begin
    lu_s = hz.ID_EX_memread && (hz.ID_EX_rd != 5'd0) &&
           ((hz.ID_EX_rd == hz.IF_ID_rs1) ||
            (hz.IF_ID_use_rs2 && (hz.ID_EX_rd == hz.IF_ID_rs2)));
    mh_s = hz.mem_req && !hz.mem_ready;
  end

  // Next-state logic and zero-latency stage controls; everything held low in reset.
  always_comb begin
    state_next_s       = state_r;
    wait_cnt_next_s    = wait_cnt_r;
    pend_flush_next_s  = pend_flush_r;
    mem_timeout_next_s = mem_timeout_r;
    pc_en_s            = 1'b0;
    if_id_en_s         = 1'b0;
    id_ex_en_s         = 1'b0;
    ex_mem_en_s        = 1'b0;
    mem_wb_en_s        = 1'b0;
    if_id_flush_s      = 1'b0;
    id_ex_flush_s      = 1'b0;
    if (Rst) begin
      state_next_s = RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (mh_s) begin
            // A branch resolving on the freeze cycle must not be lost.
            state_next_s    = MEM_WAIT;
            wait_cnt_next_s = WAIT_W'(1);
            if (hz.branch_taken) begin
              pend_flush_next_s = 1'b1;
            end else begin
              pend_flush_next_s = pend_flush_r;
            end
          end else if (hz.branch_taken || pend_flush_r) begin
            {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s} = 5'b11111;
            if_id_flush_s     = 1'b1;
            id_ex_flush_s     = 1'b1;
            pend_flush_next_s = 1'b0;
          end else if (lu_s) begin
            {id_ex_en_s, ex_mem_en_s, mem_wb_en_s} = 3'b111;
            id_ex_flush_s = 1'b1;
          end else begin
            {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s} = 5'b11111;
          end
        end
        MEM_WAIT: begin
          if (hz.branch_taken) begin
            pend_flush_next_s = 1'b1;
          end else begin
            pend_flush_next_s = pend_flush_r;
          end
          if (hz.mem_ready) begin
            mem_wb_en_s     = 1'b1;
            state_next_s    = RUN;
            wait_cnt_next_s = '0;
          end else if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT)) begin
            // Forced release: let MEM/WB move so the pipeline cannot deadlock.
            mem_wb_en_s        = 1'b1;
            mem_timeout_next_s = 1'b1;
            state_next_s       = RUN;
            wait_cnt_next_s    = '0;
          end else begin
            wait_cnt_next_s = wait_cnt_r + WAIT_W'(1);
          end
        end
        default: begin
          state_next_s    = RUN;
          wait_cnt_next_s = '0;
        end
      endcase
    end
  end

  // State, wait counter and sticky flags.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_r       <= RUN;
      wait_cnt_r    <= '0;
      pend_flush_r  <= 1'b0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      wait_cnt_r    <= wait_cnt_next_s;
      pend_flush_r  <= pend_flush_next_s;
      mem_timeout_r <= mem_timeout_next_s;
    end
  end

  // Saturating count of cycles in which the PC is frozen.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt_r <= '0;
    end else if (!pc_en_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign hz.pc_en       = pc_en_s;
  assign hz.if_id_en    = if_id_en_s;
  assign hz.id_ex_en    = id_ex_en_s;
  assign hz.ex_mem_en   = ex_mem_en_s;
  assign hz.mem_wb_en   = mem_wb_en_s;
  assign hz.if_id_flush = if_id_flush_s;
  assign hz.id_ex_flush = id_ex_flush_s;
  assign hz.mem_timeout = mem_timeout_r;
  assign hz.stall_cnt   = stall_cnt_r;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench: the driver queues hand-computed expectations, a
// negedge monitor pops and compares them against the live DUT outputs.
module tb_pipeline_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
  localparam logic [6:0] E_ZERO  = 7'b0000000;
  localparam logic [6:0] E_RUN   = 7'b1111100;
  localparam logic [6:0] E_LU    = 7'b0011101;
  localparam logic [6:0] E_FLUSH = 7'b1111111;
  localparam logic [6:0] E_STALL = 7'b0000000;
  localparam logic [6:0] E_MEMWB = 7'b0000100;

  typedef struct {
    string          name;
    logic [6:0]     en;
    logic           to;
    logic [CW-1:0]  stall;
  } exp_t;

  logic clk;
  logic Rst;
  exp_t sb_q[$];
  int   n_vec;
  int   n_miss;
  int   model_stall;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .Rst (Rst),
    .hz  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  // Monitor: one queued expectation checked per cycle, mid-cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [6:0] act;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
             bus.if_id_flush, bus.id_ex_flush};
      n_vec = n_vec + 1;
      if ((act !== e.en) || (bus.mem_timeout !== e.to) || (bus.stall_cnt !== e.stall)) begin
        n_miss = n_miss + 1;
        $display("FAIL %s: got en=%b to=%b stall=%0d, expected en=%b to=%b stall=%0d",
                 e.name, act, bus.mem_timeout, bus.stall_cnt, e.en, e.to, e.stall);
      end
    end
  end

  task automatic vec(input string name, input logic rst_v, input logic memread,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic use2, input logic br, input logic req, input logic rdy,
                     input logic [6:0] exp_en, input logic exp_to);
    exp_t e;
    @(posedge clk);
    #1;
    Rst               = rst_v;
    bus.ID_EX_memread = memread;
    bus.ID_EX_rd      = rd;
    bus.IF_ID_rs1     = rs1;
    bus.IF_ID_rs2     = rs2;
    bus.IF_ID_use_rs2 = use2;
    bus.branch_taken  = br;
    bus.mem_req       = req;
    bus.mem_ready     = rdy;
    e.name  = name;
    e.en    = exp_en;
    e.to    = exp_to;
    e.stall = rst_v ? CW'(0) : CW'(model_stall);
    sb_q.push_back(e);
    if (rst_v) begin
      model_stall = 0;
    end else if (!exp_en[6] && (model_stall < (1 << CW) - 1)) begin
      model_stall = model_stall + 1;
    end
  endtask

  initial begin
    n_vec = 0; n_miss = 0; model_stall = 0;
    Rst = 1'b1;
    bus.ID_EX_memread = 1'b0; bus.ID_EX_rd = 5'd0; bus.IF_ID_rs1 = 5'd0;
    bus.IF_ID_rs2 = 5'd0; bus.IF_ID_use_rs2 = 1'b0; bus.branch_taken = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;

    //   name            rst  ld  rd     rs1    rs2    u2  br  req rdy  exp      to
    vec("reset0",        1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_ZERO,  1'b0);
    vec("reset1",        1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, E_ZERO,  1'b0);
    vec("run_idle",      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN,   1'b0);
    vec("lu_rs1",        1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_LU,    1'b0);
    vec("lu_after",      1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN,   1'b0);
    vec("lu_rd0",        1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN,   1'b0);
    vec("lu_rs2_unused", 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN,   1'b0);
    vec("lu_rs2",        1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_LU,    1'b0);
    vec("no_load",       1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN,   1'b0);
    vec("br_over_lu",    1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_FLUSH, 1'b0);
    vec("req_and_rdy",   1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_RUN,   1'b0);
    vec("mw_enter",      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL, 1'b0);
    vec("mw_wait1",      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL, 1'b0);
    vec("mw_wait2",      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL, 1'b0);
    vec("mw_ready",      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_MEMWB, 1'b0);
    vec("mw_back_run",   1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN,   1'b0);
    vec("pf_enter",      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL, 1'b0);
    vec("pf_br_in_wait", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_STALL, 1'b0);
    vec("pf_ready",      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_MEMWB, 1'b0);
    vec("pf_flush",      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_FLUSH, 1'b0);
    vec("pf_cleared",    1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN,   1'b0);
    vec("pe_br_entry",   1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_STALL, 1'b0);
    vec("pe_ready",      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_MEMWB, 1'b0);
    vec("pe_mh_first",   1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL, 1'b0);
    vec("pe_ready2",     1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_MEMWB, 1'b0);
    vec("pe_flush_lu",   1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_FLUSH, 1'b0);
    vec("pe_cleared",    1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN,   1'b0);
    vec("to_enter",      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL, 1'b0);
    vec("to_wait1",      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL, 1'b0);
    vec("to_wait2_sat",  1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL, 1'b0);
    vec("to_wait3",      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL, 1'b0);
    vec("to_release",    1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_MEMWB, 1'b0);
    vec("to_flag",       1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN,   1'b1);
    vec("to_sticky",     1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN,   1'b1);
    vec("ar_enter",      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL, 1'b1);
    vec("ar_br_wait",    1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_STALL, 1'b1);
    vec("ar_async_rst",  1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_ZERO,  1'b0);
    vec("ar_release",    1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN,   1'b0);
    vec("ar_run",        1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN,   1'b0);

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_miss = n_miss + 1;
      $display("FAIL drain: got %0d unchecked vectors, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
